saph_fpu_cmpunit: RTL and testbench

//   FPU-side responder for the saph_fpi floating-point request/result protocol.
//   - Accepts one request per handshake and returns exactly one result a fixed

---
 rtl/saph_fpu_cmpunit.sv | 177 +++++++++++++++++
 tb/tb_saph_fpu_cmpunit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saph_fpu_cmpunit.sv
// rtl/saph_fpu_cmpunit.sv - FPU min/max/neg/abs responder with fixed-latency result return
module saph_fpu_cmpunit #(
    parameter int unsigned LATENCY   = 2,
    parameter bit          PIPELINED = 1'b1,
    parameter logic [3:0]  MODES     = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_trig,
    output logic        d_ready,
    input  logic [31:0] d_lhs,
    input  logic [31:0] d_rhs,
    input  logic [1:0]  d_mode,
    output logic        has_modes,
    output logic        q_trig,
    output logic [31:0] q_res
);

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    localparam logic [1:0] MODE_MIN = 2'd0;
    localparam logic [1:0] MODE_MAX = 2'd1;
    localparam logic [1:0] MODE_NEG = 2'd2;
    localparam logic [1:0] MODE_ABS = 2'd3;

    // Quiet or signalling: all-ones exponent with a non-zero fraction.
    function automatic logic f_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Sign-magnitude ordering; differing signs put the negative side lower,
    // which also makes -0 sort below +0.
    function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
        logic res;
        if (a[31] != b[31]) begin
            res = a[31];
        end else if (!a[31]) begin
            res = a[30:0] < b[30:0];
        end else begin
            res = a[30:0] > b[30:0];
        end
        return res;
    endfunction

    logic        w_accept;
    logic        w_lhs_nan;
    logic        w_rhs_nan;
    logic        w_rhs_lt_lhs;
    logic        w_lhs_lt_rhs;
    logic [31:0] w_res;
    logic        w_rdy;
    logic        w_trig;
    logic [31:0] w_out;

    assign w_accept     = d_trig && d_ready;
    assign w_lhs_nan    = f_is_nan(d_lhs);
    assign w_rhs_nan    = f_is_nan(d_rhs);
    assign w_rhs_lt_lhs = f_lt(d_rhs, d_lhs);
    assign w_lhs_lt_rhs = f_lt(d_lhs, d_rhs);

    // Stage 0: the whole operation is resolved from the request operands.
    always_comb begin
        w_res = CANON_NAN;
        if (MODES[d_mode]) begin
            case (d_mode)
                MODE_MIN: begin
                    if (w_lhs_nan && w_rhs_nan) begin
                        w_res = CANON_NAN;
                    end else if (w_lhs_nan || (!w_rhs_nan && w_rhs_lt_lhs)) begin
                        w_res = d_rhs;
                    end else begin
                        w_res = d_lhs;
                    end
                end
                MODE_MAX: begin
                    if (w_lhs_nan && w_rhs_nan) begin
                        w_res = CANON_NAN;
                    end else if (w_lhs_nan || (!w_rhs_nan && w_lhs_lt_rhs)) begin
                        w_res = d_rhs;
                    end else begin
                        w_res = d_lhs;
                    end
                end
                MODE_NEG: w_res = {~d_lhs[31], d_lhs[30:0]};
                MODE_ABS: w_res = {1'b0, d_lhs[30:0]};
                default:  w_res = CANON_NAN;
            endcase
        end
    end

    generate
        if (PIPELINED) begin : g_pipe
            logic [LATENCY-1:0] r_vld;
            logic [31:0]        r_dat [LATENCY];

            // Valid bits march one stage per cycle; reset drops everything in flight.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= w_accept;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_vld[i] <= r_vld[i-1];
                    end
                end
            end

            // Result data follows its valid bit; contents only matter where valid.
            always_ff @(posedge clk) begin
                r_dat[0] <= w_res;
                for (int i = 1; i < LATENCY; i++) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end

            assign w_rdy  = 1'b1;
            assign w_trig = r_vld[LATENCY-1];
            assign w_out  = r_dat[LATENCY-1];
        end else begin : g_fsm
            typedef enum logic {S_IDLE, S_BUSY} state_t;

            state_t      r_state;
            logic [3:0]  r_cnt;
            logic        r_qv;
            logic [31:0] r_dat;

            // One request in flight: count down LATENCY cycles, pulse, then reopen.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                    r_qv    <= 1'b0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            r_qv <= w_accept && (LATENCY == 1);
                            if (w_accept) begin
                                r_state <= S_BUSY;
                                r_cnt   <= 4'(LATENCY - 1);
                            end
                        end
                        S_BUSY: begin
                            if (r_cnt == 4'd0) begin
                                r_state <= S_IDLE;
                                r_qv    <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt - 4'd1;
                                r_qv  <= (r_cnt == 4'd1);
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_qv    <= 1'b0;
                        end
                    endcase
                end
            end

            // Result captured once at accept so later operand changes are ignored.
            always_ff @(posedge clk) begin
                if (w_accept) begin
                    r_dat <= w_res;
                end
            end

            assign w_rdy  = (r_state == S_IDLE);
            assign w_trig = r_qv;
            assign w_out  = r_dat;
        end
    endgenerate

    assign d_ready   = rst_n && w_rdy;
    assign q_trig    = rst_n && w_trig;
    assign q_res     = q_trig ? w_out : 32'h0;
    assign has_modes = (MODES != 4'h0);

endmodule

// File: tb/tb_saph_fpu_cmpunit.sv
// tb/tb_saph_fpu_cmpunit.sv - self-checking bench for saph_fpu_cmpunit
module tb_saph_fpu_cmpunit;

    localparam int          LAT   = 2;
    localparam int          SLAT  = 3;
    localparam logic [31:0] CANON = 32'h7FC0_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        d_trig;
    logic [31:0] d_lhs, d_rhs;
    logic [1:0]  d_mode;
    logic        s_d_trig;
    logic [31:0] s_d_lhs, s_d_rhs;
    logic [1:0]  s_d_mode;

    logic        p_ready, p_has, p_trig;
    logic [31:0] p_res;
    logic        l_ready, l_has, l_trig;
    logic [31:0] l_res;
    logic        s_ready, s_has, s_trig;
    logic [31:0] s_res;

    int errors = 0;
    int checks = 0;

    logic [31:0] pool [10] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                              32'h7FC0_0000, 32'h7F80_0001, 32'hFFC0_0123, 32'h3F80_0000,
                              32'hBF80_0000, 32'h0000_0001};

    saph_fpu_cmpunit #(.LATENCY(LAT), .PIPELINED(1'b1), .MODES(4'hF)) u_pipe (
        .clk(clk), .rst_n(rst_n), .d_trig(d_trig), .d_ready(p_ready),
        .d_lhs(d_lhs), .d_rhs(d_rhs), .d_mode(d_mode), .has_modes(p_has),
        .q_trig(p_trig), .q_res(p_res));

    saph_fpu_cmpunit #(.LATENCY(LAT), .PIPELINED(1'b1), .MODES(4'h3)) u_lim (
        .clk(clk), .rst_n(rst_n), .d_trig(d_trig), .d_ready(l_ready),
        .d_lhs(d_lhs), .d_rhs(d_rhs), .d_mode(d_mode), .has_modes(l_has),
        .q_trig(l_trig), .q_res(l_res));

    saph_fpu_cmpunit #(.LATENCY(SLAT), .PIPELINED(1'b0), .MODES(4'hF)) u_seq (
        .clk(clk), .rst_n(rst_n), .d_trig(s_d_trig), .d_ready(s_ready),
        .d_lhs(s_d_lhs), .d_rhs(s_d_rhs), .d_mode(s_d_mode), .has_modes(s_has),
        .q_trig(s_trig), .q_res(s_res));

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Maps a float to an integer rank: -0 -> -1, +0 -> 0, larger magnitude
    // negatives further below.
    function automatic longint order_key(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? (-m - 1) : m;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] lhs, input logic [31:0] rhs,
                                          input logic [1:0] mode, input logic [3:0] mask);
        logic [31:0] r;
        if (!mask[mode]) begin
            r = CANON;
        end else if (mode == 2'd2) begin
            r = lhs ^ 32'h8000_0000;
        end else if (mode == 2'd3) begin
            r = lhs & 32'h7FFF_FFFF;
        end else if (is_nan(lhs) && is_nan(rhs)) begin
            r = CANON;
        end else if (is_nan(lhs)) begin
            r = rhs;
        end else if (is_nan(rhs)) begin
            r = lhs;
        end else if (mode == 2'd0) begin
            r = (order_key(rhs) < order_key(lhs)) ? rhs : lhs;
        end else begin
            r = (order_key(rhs) > order_key(lhs)) ? rhs : lhs;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        logic [31:0] o;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       o = pool[$urandom_range(0, 9)];
            1:       o = r;
            2:       o = {r[31], 8'hFF, 21'd0, r[1:0]};
            default: o = {r[31], 8'h7F, r[22:0]};
        endcase
        return o;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; d_trig = 1'b1; d_lhs = 32'h3F80_0000; d_rhs = 32'h4000_0000; d_mode = 2'd1;
        s_d_trig = 1'b1; s_d_lhs = 32'h3F80_0000; s_d_rhs = 32'h0; s_d_mode = 2'd2;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({p_trig, l_trig, s_trig, p_ready, l_ready, s_ready} !== 6'b0 ||
                p_res !== 32'h0 || l_res !== 32'h0 || s_res !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs: trig=%b%b%b ready=%b%b%b res=%h/%h/%h, want all zero",
                         p_trig, l_trig, s_trig, p_ready, l_ready, s_ready, p_res, l_res, s_res);
            end
        end
        checks++;
        if ({p_has, l_has, s_has} !== 3'b111) begin
            errors++;
            $display("FAIL has_modes: got %b, want 111", {p_has, l_has, s_has});
        end
        rst_n = 1'b1; d_trig = 1'b0; s_d_trig = 1'b0;
        #1;
        checks++;
        if ({p_ready, l_ready, s_ready} !== 3'b111 || {p_trig, l_trig, s_trig} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: ready=%b trig=%b, want ready=111 trig=000",
                     {p_ready, l_ready, s_ready}, {p_trig, l_trig, s_trig});
        end
    endtask

    task automatic test_directed();
        bit          v [12];
        logic [1:0]  m [12];
        logic [31:0] a [12];
        logic [31:0] b [12];
        logic [31:0] e [12];
        logic        exp_t;
        logic [31:0] exp_p, exp_l;
        v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        m = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd1};
        a = '{32'h3F80_0000, 32'h0, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0001, 32'h7FC0_0001,
              32'h3F80_0000, 32'h4000_0000, 32'hC040_0000, 32'h0000_0000, 32'hFF80_0000, 32'hC000_0000};
        b = '{32'h4000_0000, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'hBF80_0000, 32'hFFC0_0000,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hBF80_0000};
        e = '{32'h4000_0000, 32'h0, 32'h8000_0000, 32'h0000_0000, 32'hBF80_0000, 32'h7FC0_0000,
              32'hBF80_0000, 32'hC000_0000, 32'h4040_0000, 32'h8000_0000, 32'h7F80_0000, 32'hBF80_0000};
        for (int j = 0; j < 12 + LAT + 1; j++) begin
            @(negedge clk);
            exp_t = 1'b0; exp_p = 32'h0; exp_l = 32'h0;
            if (j >= LAT) begin
                if (v[j-LAT]) begin
                    exp_t = 1'b1;
                    exp_p = e[j-LAT];
                    exp_l = (m[j-LAT] >= 2'd2) ? CANON : e[j-LAT];
                end
            end
            checks++;
            if (p_trig !== exp_t || p_res !== exp_p) begin
                errors++;
                $display("FAIL directed_full[%0d]: got trig=%b res=%h, want trig=%b res=%h",
                         j, p_trig, p_res, exp_t, exp_p);
            end
            checks++;
            if (l_trig !== exp_t || l_res !== exp_l) begin
                errors++;
                $display("FAIL directed_masked[%0d]: got trig=%b res=%h, want trig=%b res=%h",
                         j, l_trig, l_res, exp_t, exp_l);
            end
            if (j < 12) begin
                d_trig = v[j]; d_mode = m[j];
                d_lhs  = v[j] ? a[j] : $urandom;
                d_rhs  = v[j] ? b[j] : $urandom;
            end else begin
                d_trig = 1'b0;
            end
        end
    endtask

    task automatic test_random_stream();
        localparam int N = 48;
        bit          v [N];
        logic [31:0] ep [N];
        logic [31:0] el [N];
        logic        exp_t;
        logic [31:0] exp_p, exp_l;
        for (int j = 0; j < N + LAT + 1; j++) begin
            @(negedge clk);
            exp_t = 1'b0; exp_p = 32'h0; exp_l = 32'h0;
            if (j >= LAT) begin
                if (v[j-LAT]) begin
                    exp_t = 1'b1; exp_p = ep[j-LAT]; exp_l = el[j-LAT];
                end
            end
            checks++;
            if (p_trig !== exp_t || p_res !== exp_p) begin
                errors++;
                $display("FAIL random_full[%0d]: got trig=%b res=%h, want trig=%b res=%h",
                         j, p_trig, p_res, exp_t, exp_p);
            end
            checks++;
            if (l_trig !== exp_t || l_res !== exp_l) begin
                errors++;
                $display("FAIL random_masked[%0d]: got trig=%b res=%h, want trig=%b res=%h",
                         j, l_trig, l_res, exp_t, exp_l);
            end
            if (j < N) begin
                v[j]   = ($urandom_range(0, 9) < 7);
                d_trig = v[j];
                d_lhs  = rand_fp();
                d_rhs  = ($urandom_range(0, 7) == 0) ? d_lhs : rand_fp();
                d_mode = 2'($urandom_range(0, 3));
                ep[j]  = model(d_lhs, d_rhs, d_mode, 4'hF);
                el[j]  = model(d_lhs, d_rhs, d_mode, 4'h3);
            end else begin
                d_trig = 1'b0;
            end
        end
    endtask

    task automatic test_fsm_held();
        localparam int K = 5;
        localparam int P = SLAT + 1;
        logic [31:0] se [K];
        logic        exp_r, exp_t;
        logic [31:0] exp_s;
        int          k, ph;
        for (int j = 0; j < K * P + 2; j++) begin
            @(negedge clk);
            k = j / P;
            ph = j % P;
            exp_r = (k >= K) || (ph == 0);
            exp_t = (k < K) && (ph == SLAT);
            exp_s = exp_t ? se[k] : 32'h0;
            checks++;
            if (s_ready !== exp_r || s_trig !== exp_t || s_res !== exp_s) begin
                errors++;
                $display("FAIL fsm_held[%0d]: got ready=%b trig=%b res=%h, want ready=%b trig=%b res=%h",
                         j, s_ready, s_trig, s_res, exp_r, exp_t, exp_s);
            end
            if (k < K) begin
                s_d_trig = 1'b1;
                s_d_lhs  = rand_fp();
                s_d_rhs  = rand_fp();
                s_d_mode = 2'($urandom_range(0, 3));
                if (ph == 0) begin
                    se[k] = model(s_d_lhs, s_d_rhs, s_d_mode, 4'hF);
                end
            end else begin
                s_d_trig = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        d_trig = 1'b1; d_lhs = 32'hFF80_0000; d_rhs = 32'h0; d_mode = 2'd3;
        @(negedge clk);
        d_trig = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (p_trig !== 1'b0 || l_trig !== 1'b0) begin
            errors++;
            $display("FAIL midflight_in_reset: got trig=%b%b, want 00", p_trig, l_trig);
        end
        rst_n = 1'b1;
        #1;
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (p_trig !== 1'b0 || l_trig !== 1'b0 || p_res !== 32'h0) begin
                errors++;
                $display("FAIL midflight_dropped[%0d]: got trig=%b%b res=%h, want 00 and 0",
                         j, p_trig, l_trig, p_res);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_stream();
        test_fsm_held();
        test_reset_midflight();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
